// File: rtl/prf_alloc_file_if.sv
// Bundle of the allocate/read/write/release/wake channels of the physical register file.
// master drives requests (issue path), slave is the register file itself.
interface prf_alloc_file_if #(
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned DATA_W       = 32
);
  localparam int unsigned PW  = $clog2(NUM_PHY_REGS);
  localparam int unsigned CW  = $clog2(NUM_PHY_REGS + 1);
  localparam int unsigned NRD = NUM_CLIENTS * NUM_RD_PORTS;

  logic [NUM_CLIENTS-1:0]             alloc_req;
  logic [NUM_CLIENTS-1:0]             alloc_gnt;
  logic [NUM_CLIENTS-1:0][PW-1:0]     alloc_pr;
  logic [NRD-1:0][PW-1:0]             rd_addr;
  logic [NRD-1:0][DATA_W-1:0]         rd_data;
  logic [NRD-1:0]                     rd_valid;
  logic [NUM_CLIENTS-1:0]             wr_en;
  logic [NUM_CLIENTS-1:0][PW-1:0]     wr_addr;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] wr_data;
  logic [NUM_CLIENTS-1:0]             rel_en;
  logic [NUM_CLIENTS-1:0][PW-1:0]     rel_pr;
  logic [NUM_CLIENTS-1:0]             wake_valid;
  logic [NUM_CLIENTS-1:0][PW-1:0]     wake_pr;
  logic [CW-1:0]                      free_count;
  logic                               err_double_write;
  logic                               err_bad_release;

  modport master (
    output alloc_req, rd_addr, wr_en, wr_addr, wr_data, rel_en, rel_pr,
    input  alloc_gnt, alloc_pr, rd_data, rd_valid, wake_valid, wake_pr, free_count,
           err_double_write, err_bad_release
  );

  modport slave (
    input  alloc_req, rd_addr, wr_en, wr_addr, wr_data, rel_en, rel_pr,
    output alloc_gnt, alloc_pr, rd_data, rd_valid, wake_valid, wake_pr, free_count,
           err_double_write, err_bad_release
  );
endinterface

// File: rtl/prf_alloc_file.sv
// Physical register file with an integrated circular free list, per-PR valid bits,
// same-cycle write bypass on reads and registered wake-up broadcast. PR0 reads as zero.
module prf_alloc_file #(
  parameter int unsigned NUM_PHY_REGS  = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_CLIENTS   = 2,
  parameter int unsigned NUM_RD_PORTS  = 2,
  parameter int unsigned DATA_W        = 32
) (
  input logic             clk,
  input logic             rst_n,
  prf_alloc_file_if.slave bus
);
  localparam int unsigned PW          = $clog2(NUM_PHY_REGS);
  localparam int unsigned CW          = $clog2(NUM_PHY_REGS + 1);
  localparam int unsigned NRD         = NUM_CLIENTS * NUM_RD_PORTS;
  localparam int unsigned NumInitFree = NUM_PHY_REGS - NUM_ARCH_REGS;

  logic [DATA_W-1:0]              regs_q [NUM_PHY_REGS];
  logic [DATA_W-1:0]              regs_d [NUM_PHY_REGS];
  logic [PW-1:0]                  fifo_q [NUM_PHY_REGS];
  logic [PW-1:0]                  fifo_d [NUM_PHY_REGS];
  logic [NUM_PHY_REGS-1:0]        vld_q, vld_d, free_q, free_d;
  logic [PW-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [NUM_CLIENTS-1:0]         wake_valid_q, wake_valid_d;
  logic [NUM_CLIENTS-1:0][PW-1:0] wake_pr_q, wake_pr_d;
  logic                           err_dw_q, err_dw_d, err_br_q, err_br_d;

  logic [NUM_CLIENTS-1:0]         gnt, rel_ok, wr_ok;
  logic [NUM_CLIENTS-1:0][PW-1:0] gnt_pr;
  logic [NUM_PHY_REGS-1:0]        gnt_mask, rel_mask;
  logic [CW-1:0]                  n_gnt, n_rel;
  logic                           bad_rel, bad_wr;
  logic [NRD-1:0][DATA_W-1:0]     rd_data;
  logic [NRD-1:0]                 rd_valid;

  // Fixed-priority grants, consecutive entries from the free-list head
  always_comb begin
    gnt      = '0;
    gnt_pr   = '0;
    gnt_mask = '0;
    n_gnt    = '0;
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      if (bus.alloc_req[c] && (n_gnt < count_q)) begin
        gnt[c]              = 1'b1;
        gnt_pr[c]           = fifo_q[head_q + n_gnt[PW-1:0]];
        gnt_mask[gnt_pr[c]] = 1'b1;
        n_gnt               = n_gnt + CW'(1);
      end
    end
  end

  // Release and write acceptance; all checks use start-of-cycle state, release beats write
  always_comb begin
    rel_ok   = '0;
    rel_mask = '0;
    n_rel    = '0;
    bad_rel  = 1'b0;
    wr_ok    = '0;
    bad_wr   = 1'b0;
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      if (bus.rel_en[c]) begin
        if (bus.rel_pr[c] == '0 || free_q[bus.rel_pr[c]] || rel_mask[bus.rel_pr[c]]) begin
          bad_rel = 1'b1;
        end else begin
          rel_ok[c]                = 1'b1;
          rel_mask[bus.rel_pr[c]]  = 1'b1;
          n_rel                    = n_rel + CW'(1);
        end
      end
    end
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      if (bus.wr_en[c] && bus.wr_addr[c] != '0 && !rel_mask[bus.wr_addr[c]]) begin
        if (vld_q[bus.wr_addr[c]] || free_q[bus.wr_addr[c]]) bad_wr   = 1'b1;
        else                                                 wr_ok[c] = 1'b1;
      end
    end
  end

  // Next state: grants consume, releases push at tail, accepted writes fill and wake
  always_comb begin
    logic [PW-1:0] wptr;
    regs_d   = regs_q;
    fifo_d   = fifo_q;
    vld_d    = vld_q;
    free_d   = free_q;
    head_d   = head_q + n_gnt[PW-1:0];
    wptr     = tail_q;
    count_d  = count_q - n_gnt + n_rel;
    err_dw_d = err_dw_q | bad_wr;
    err_br_d = err_br_q | bad_rel;
    for (int unsigned p = 0; p < NUM_PHY_REGS; p++) begin
      if (gnt_mask[p]) begin
        vld_d[p]  = 1'b0;
        free_d[p] = 1'b0;
        regs_d[p] = 'x;
      end
    end
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      if (rel_ok[c]) begin
        fifo_d[wptr]          = bus.rel_pr[c];
        wptr                  = wptr + PW'(1);
        free_d[bus.rel_pr[c]] = 1'b1;
        vld_d[bus.rel_pr[c]]  = 1'b0;
      end
    end
    tail_d = wptr;
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      wake_valid_d[c] = wr_ok[c];
      wake_pr_d[c]    = wr_ok[c] ? bus.wr_addr[c] : '0;
      if (wr_ok[c]) begin
        regs_d[bus.wr_addr[c]] = bus.wr_data[c];
        vld_d[bus.wr_addr[c]]  = 1'b1;
      end
    end
  end

  // Reads: PR0 is constant zero, otherwise the latest accepted write bypasses the array
  always_comb begin
    for (int unsigned r = 0; r < NRD; r++) begin
      rd_data[r]  = regs_q[bus.rd_addr[r]];
      rd_valid[r] = vld_q[bus.rd_addr[r]];
      for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
        if (wr_ok[c] && bus.wr_addr[c] == bus.rd_addr[r]) begin
          rd_data[r]  = bus.wr_data[c];
          rd_valid[r] = 1'b1;
        end
      end
      if (bus.rd_addr[r] == '0) begin
        rd_data[r]  = '0;
        rd_valid[r] = 1'b1;
      end
    end
  end

  // State registers; reset restores the architectural mapping and the initial free list
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NUM_PHY_REGS; p++) begin
        regs_q[p] <= '0;
        vld_q[p]  <= (p < NUM_ARCH_REGS);
        free_q[p] <= (p >= NUM_ARCH_REGS);
        fifo_q[p] <= (p < NumInitFree) ? PW'(NUM_ARCH_REGS + p) : '0;
      end
      head_q       <= '0;
      tail_q       <= PW'(NumInitFree);
      count_q      <= CW'(NumInitFree);
      wake_valid_q <= '0;
      wake_pr_q    <= '0;
      err_dw_q     <= 1'b0;
      err_br_q     <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      vld_q        <= vld_d;
      free_q       <= free_d;
      fifo_q       <= fifo_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      wake_valid_q <= wake_valid_d;
      wake_pr_q    <= wake_pr_d;
      err_dw_q     <= err_dw_d;
      err_br_q     <= err_br_d;
    end
  end

  assign bus.alloc_gnt        = gnt;
  assign bus.alloc_pr         = gnt_pr;
  assign bus.rd_data          = rd_data;
  assign bus.rd_valid         = rd_valid;
  assign bus.wake_valid       = wake_valid_q;
  assign bus.wake_pr          = wake_pr_q;
  assign bus.free_count       = count_q;
  assign bus.err_double_write = err_dw_q;
  assign bus.err_bad_release  = err_br_q;

  // Unknown addresses under an enable would silently corrupt the free list
  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_xchk
    a_wr_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wr_en[c] |-> !$isunknown(bus.wr_addr[c]))
      else $fatal(1, "unknown wr_addr on client %0d", c);
    a_rel_pr_known: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rel_en[c] |-> !$isunknown(bus.rel_pr[c]))
      else $fatal(1, "unknown rel_pr on client %0d", c);
  end
endmodule
